tile_map_store: RTL and testbench

Tile map memory that serves packed sprite indices to the pixel generator and accepts edits from the game controller. The display side presents a word address derived from its current tile and receives a 32-bit word holding eight 4-bit sprite indices, one per tile. The host side writes single tiles, whole words or a full-screen fill through a valid/ready handshake. It sits between the game logic and the pixel generator in the video path.

---
 rtl/tile_map_store.sv | 209 ++++++++++++++++++++
 tb/tb_tile_map_store.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_store.sv
// tile_map_store: dual-port tile map holding eight 4-bit sprite indices per
// 32-bit word. Port A serves the pixel generator with a registered 1-cycle
// read. Port B belongs to the host, which can write single tiles (via
// read-modify-write), whole words, or fill the whole screen.
// Optional build macro: TILE_MAP_CLEAR_ON_RESET_EN. When it is defined, the
// store clears itself to index 0 right after reset is released.
module tile_map_store (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  rd_word,
    output logic [31:0] sprite_addr,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_mode,
    input  logic [10:0] wr_tile,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done
);

    localparam int N_TILES_X      = 60;
    localparam int N_TILES_Y      = 34;
    localparam int IDX_W          = 4;
    localparam int TILES_PER_WORD = 8;
    localparam int DEPTH          = 255;

    localparam logic [10:0] N_TILES_L = 11'(N_TILES_X * N_TILES_Y);
    localparam logic [8:0]  DEPTH_W9  = 9'(DEPTH);
    localparam logic [7:0]  DEPTH_B   = 8'(DEPTH);
    localparam logic [7:0]  LAST_B    = 8'(DEPTH - 1);

    localparam logic [1:0] MODE_TILE = 2'b00;
    localparam logic [1:0] MODE_WORD = 2'b01;
    localparam logic [1:0] MODE_FILL = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RMW_RD = 2'b01,
        RMW_WR = 2'b10,
        FILL   = 2'b11
    } state_t;

    // Replace one 4-bit slot of a packed word with a new sprite index.
    function automatic logic [31:0] put_slot(input logic [31:0] word,
                                             input logic [2:0]  slot,
                                             input logic [IDX_W-1:0] idx);
        logic [31:0] res;
        res = word;
        res[{slot, 2'b00} +: IDX_W] = idx;
        return res;
    endfunction

    logic [31:0]      mem_r [0:DEPTH-1];
    state_t           state_r;
    logic [10:0]      tile_r;
    logic [7:0]       word_r;
    logic [IDX_W-1:0] idx_r;
    logic [7:0]       cnt_r;
    logic             oor_r;
    logic [31:0]      hold_r;
    logic             busy_r;
    logic             ready_r;
    logic             done_r;
    logic [31:0]      sprite_r;

    logic             we_s;
    logic [7:0]       waddr_s;
    logic [31:0]      wdata_s;

    assign wr_ready    = ready_r & rst_n;
    assign busy        = busy_r & rst_n;
    assign done        = done_r;
    assign sprite_addr = sprite_r;

    // Display port: registered read, read-first against a same-cycle host write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sprite_r <= 32'h0;
        end else if (rd_word < DEPTH_W9) begin
            sprite_r <= mem_r[rd_word[7:0]];
        end else begin
            sprite_r <= 32'h0;
        end
    end

    // Host-port write select: word commit, RMW write-back or fill sweep.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = 8'h00;
        wdata_s = 32'h0;
        if (rst_n) begin
            case (state_r)
                IDLE: begin
                    if (wr_valid && (wr_mode == MODE_WORD) && (wr_tile[10:3] < DEPTH_B)) begin
                        we_s    = 1'b1;
                        waddr_s = wr_tile[10:3];
                        wdata_s = wr_data;
                    end else begin
                        we_s    = 1'b0;
                    end
                end
                RMW_WR: begin
                    if (!oor_r) begin
                        we_s    = 1'b1;
                        waddr_s = word_r;
                        wdata_s = put_slot(hold_r, tile_r[2:0], idx_r);
                    end else begin
                        we_s    = 1'b0;
                    end
                end
                FILL: begin
                    we_s    = 1'b1;
                    waddr_s = cnt_r;
                    wdata_s = {TILES_PER_WORD{idx_r}};
                end
                default: begin
                    we_s    = 1'b0;
                end
            endcase
        end else begin
            we_s = 1'b0;
        end
    end

    // Host-port storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[waddr_s] <= wdata_s;
        end
    end

    // Host request FSM with registered ready/busy/done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
`ifdef TILE_MAP_CLEAR_ON_RESET_EN
            state_r <= FILL;
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
`else
            state_r <= IDLE;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
`endif
            tile_r  <= 11'd0;
            word_r  <= 8'd0;
            idx_r   <= {IDX_W{1'b0}};
            cnt_r   <= 8'd0;
            oor_r   <= 1'b0;
            hold_r  <= 32'h0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (wr_valid) begin
                        case (wr_mode)
                            MODE_TILE: begin
                                tile_r  <= wr_tile;
                                word_r  <= wr_tile[10:3];
                                idx_r   <= wr_data[IDX_W-1:0];
                                oor_r   <= (wr_tile >= N_TILES_L);
                                state_r <= RMW_RD;
                                busy_r  <= 1'b1;
                                ready_r <= 1'b0;
                            end
                            MODE_FILL: begin
                                idx_r   <= wr_data[IDX_W-1:0];
                                cnt_r   <= 8'd0;
                                state_r <= FILL;
                                busy_r  <= 1'b1;
                                ready_r <= 1'b0;
                            end
                            default: begin
                                // Word writes commit at this edge; reserved mode is a no-op.
                                done_r <= 1'b1;
                            end
                        endcase
                    end
                end
                RMW_RD: begin
                    hold_r  <= (word_r < DEPTH_B) ? mem_r[word_r] : 32'h0;
                    state_r <= RMW_WR;
                end
                RMW_WR: begin
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                FILL: begin
                    if (cnt_r == LAST_B) begin
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_map_store.sv
// Self-checking bench for tile_map_store: randomized host traffic against an
// array model of the tile map, with display reads as the observation path.
module tb_tile_map_store;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  rd_word;
    logic [31:0] sprite_addr;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_mode;
    logic [10:0] wr_tile;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [0:254];
    logic [3:0]  last_fill = 4'h0;

    always #5 clk = ~clk;

    tile_map_store dut (
        .clk(clk), .rst_n(rst_n), .rd_word(rd_word), .sprite_addr(sprite_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_mode(wr_mode),
        .wr_tile(wr_tile), .wr_data(wr_data), .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        int dn;
        rst_n = 1'b0; wr_valid = 1'b0; wr_mode = 2'b00; wr_tile = 11'd0;
        wr_data = 32'h0; rd_word = 9'd0;
        tick(); tick(); tick();
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (sprite_addr !== 32'h0) begin errors++; $display("FAIL reset_sprite got %h want 0", sprite_addr); end
        rst_n = 1'b1;
`ifdef TILE_MAP_CLEAR_ON_RESET_EN
        n = 0; dn = 0;
        while (busy === 1'b1 && n < 400) begin
            if (done === 1'b1) dn++;
            n++;
            tick();
        end
        checks++; if (n != 255) begin errors++; $display("FAIL reset_clear_busy_cycles got %0d want 255", n); end
        checks++; if (done !== 1'b1 || dn != 0) begin errors++; $display("FAIL reset_clear_done got %b early %0d want 1 early 0", done, dn); end
        for (int i = 0; i < 255; i++) ref_mem[i] = 32'h0;
        for (int a = 0; a < 255; a++) begin
            rd_word = 9'(a); tick();
            checks++; if (sprite_addr !== ref_mem[a]) begin errors++; $display("FAIL reset_clear_word%0d got %h want %h", a, sprite_addr, ref_mem[a]); end
        end
`else
        n = 0; dn = 0;
        tick();
        checks++; if (wr_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_release got ready %b busy %b want 1 0", wr_ready, busy); end
`endif
    endtask

    task automatic test_fill(input logic [3:0] idx, input bit coll);
        int n;
        int dn;
        int c;
        logic [31:0] old_c;
        c = $urandom_range(0, 252);
        old_c = ref_mem[c];
        rd_word = 9'(c);
        wr_valid = 1'b1; wr_mode = 2'b10; wr_tile = 11'($urandom); wr_data = {$urandom} & 32'hFFFF_FFF0 | {28'h0, idx};
        tick();
        wr_valid = 1'b0;
        n = 0; dn = 0;
        while (wr_ready !== 1'b1 && n < 400) begin
            if (done === 1'b1) dn++;
            if (coll && n == c + 1) begin
                checks++; if (sprite_addr !== old_c) begin errors++; $display("FAIL fill_collision_old w%0d got %h want %h", c, sprite_addr, old_c); end
            end
            if (coll && n == c + 2) begin
                checks++; if (sprite_addr !== {8{idx}}) begin errors++; $display("FAIL fill_collision_new w%0d got %h want %h", c, sprite_addr, {8{idx}}); end
            end
            n++;
            tick();
        end
        checks++; if (n != 255) begin errors++; $display("FAIL fill_ready_low got %0d want 255", n); end
        checks++; if (done !== 1'b1 || dn != 0) begin errors++; $display("FAIL fill_done got %b early %0d want 1 early 0", done, dn); end
        for (int i = 0; i < 255; i++) ref_mem[i] = {8{idx}};
        last_fill = idx;
        for (int a = 0; a < 255; a++) begin
            rd_word = 9'(a); tick();
            checks++; if (sprite_addr !== ref_mem[a]) begin errors++; $display("FAIL fill_word%0d got %h want %h", a, sprite_addr, ref_mem[a]); end
        end
    endtask

    task automatic test_word_write();
        logic [31:0] d;
        int a;
        wr_valid = 1'b1; wr_mode = 2'b01; wr_tile = 11'd40; wr_data = 32'h76543210;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL word_ready got %b want 1", wr_ready); end
        tick();
        ref_mem[5] = 32'h76543210;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL word_done got %b want 1", done); end
        d = $urandom;
        wr_tile = 11'd58; wr_data = d;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL word_b2b_ready got %b want 1", wr_ready); end
        tick();
        ref_mem[7] = d;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL word_b2b_done got %b want 1", done); end
        wr_valid = 1'b0;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL word_done_drop got %b want 0", done); end
        rd_word = 9'd5; tick();
        checks++; if (sprite_addr !== 32'h76543210) begin errors++; $display("FAIL word_w5 got %h want 76543210", sprite_addr); end
        rd_word = 9'd7; tick();
        checks++; if (sprite_addr !== ref_mem[7]) begin errors++; $display("FAIL word_w7 got %h want %h", sprite_addr, ref_mem[7]); end
    endtask

    task automatic test_random_words();
        int a;
        logic [31:0] d;
        wr_valid = 1'b1; wr_mode = 2'b01;
        for (int k = 0; k < 24; k++) begin
            a = (k % 6 == 5) ? 255 : $urandom_range(8, 255);
            d = $urandom;
            wr_tile = 11'(a * 8 + $urandom_range(0, 7)); wr_data = d;
            tick();
            if (a < 255) ref_mem[a] = d;
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL rword_done k%0d got %b want 1", k, done); end
        end
        wr_valid = 1'b0;
        for (int w = 0; w < 255; w++) begin
            rd_word = 9'(w); tick();
            checks++; if (sprite_addr !== ref_mem[w]) begin errors++; $display("FAIL rword_word%0d got %h want %h", w, sprite_addr, ref_mem[w]); end
        end
    endtask

    task automatic tile_req(input int t, input logic [3:0] idx, input string tag);
        int n;
        int dn;
        wr_valid = 1'b1; wr_mode = 2'b00; wr_tile = 11'(t); wr_data = {$urandom} & 32'hFFFF_FFF0 | {28'h0, idx};
        tick();
        wr_valid = 1'b0;
        n = 0; dn = 0;
        while (wr_ready !== 1'b1 && n < 10) begin
            if (done === 1'b1) dn++;
            n++;
            tick();
        end
        checks++; if (n != 2) begin errors++; $display("FAIL %s_ready_low t%0d got %0d want 2", tag, t, n); end
        checks++; if (done !== 1'b1 || dn != 0) begin errors++; $display("FAIL %s_done t%0d got %b early %0d want 1 early 0", tag, t, done, dn); end
        if (t < 60 * 34) begin
            ref_mem[t / 8] = (ref_mem[t / 8] & ~(32'hF << (4 * (t % 8)))) | ({28'h0, idx} << (4 * (t % 8)));
        end
    endtask

    task automatic test_tile_write();
        int t;
        tile_req(43, 4'hA, "tile");
        rd_word = 9'd5; tick();
        checks++; if (sprite_addr !== 32'h7654A210) begin errors++; $display("FAIL tile_w5 got %h want 7654a210", sprite_addr); end
        for (int k = 0; k < 30; k++) begin
            t = (k % 7 == 6) ? $urandom_range(2040, 2047) : $urandom_range(0, 2039);
            tile_req(t, 4'($urandom), "rtile");
        end
        for (int w = 0; w < 255; w++) begin
            rd_word = 9'(w); tick();
            checks++; if (sprite_addr !== ref_mem[w]) begin errors++; $display("FAIL rtile_word%0d got %h want %h", w, sprite_addr, ref_mem[w]); end
        end
    endtask

    task automatic test_out_of_range();
        tile_req(2040, 4'h5, "oor_tile");
        rd_word = 9'd254; tick();
        checks++; if (sprite_addr !== ref_mem[254]) begin errors++; $display("FAIL oor_w254 got %h want %h", sprite_addr, ref_mem[254]); end
        rd_word = 9'd300; tick();
        checks++; if (sprite_addr !== 32'h0) begin errors++; $display("FAIL oor_rd300 got %h want 0", sprite_addr); end
        rd_word = 9'd255; tick();
        checks++; if (sprite_addr !== 32'h0) begin errors++; $display("FAIL oor_rd255 got %h want 0", sprite_addr); end
        rd_word = 9'd511; tick();
        checks++; if (sprite_addr !== 32'h0) begin errors++; $display("FAIL oor_rd511 got %h want 0", sprite_addr); end
        wr_valid = 1'b1; wr_mode = 2'b11; wr_tile = 11'd0; wr_data = 32'hFFFF_FFFF;
        tick();
        wr_valid = 1'b0;
        checks++; if (done !== 1'b1 || wr_ready !== 1'b1) begin errors++; $display("FAIL reserved got done %b ready %b want 1 1", done, wr_ready); end
        for (int w = 0; w < 255; w++) begin
            rd_word = 9'(w); tick();
            checks++; if (sprite_addr !== ref_mem[w]) begin errors++; $display("FAIL oor_word%0d got %h want %h", w, sprite_addr, ref_mem[w]); end
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [3:0] v;
        int dn;
        int n;
        v = last_fill ^ 4'($urandom_range(1, 15));
        wr_valid = 1'b1; wr_mode = 2'b10; wr_tile = 11'd0; wr_data = {28'h0, v};
        tick();
        wr_valid = 1'b0;
        repeat (100) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
`ifdef TILE_MAP_CLEAR_ON_RESET_EN
        n = 0; dn = 0;
        while (busy === 1'b1 && n < 400) begin
            if (done === 1'b1) dn++;
            n++;
            tick();
        end
        checks++; if (n != 255 || done !== 1'b1 || dn != 0) begin errors++; $display("FAIL midfill_clear got cycles %0d done %b early %0d want 255 1 0", n, done, dn); end
        for (int i = 0; i < 255; i++) ref_mem[i] = 32'h0;
`else
        tick();
        checks++; if (wr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midfill_idle got ready %b busy %b done %b want 1 0 0", wr_ready, busy, done); end
        dn = 0; n = 0;
        repeat (10) begin
            if (done === 1'b1) dn++;
            tick();
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL midfill_no_done got %0d want 0", dn); end
        for (int i = 0; i < 100; i++) ref_mem[i] = {8{v}};
`endif
        for (int w = 0; w < 255; w++) begin
            rd_word = 9'(w); tick();
            checks++; if (sprite_addr !== ref_mem[w]) begin errors++; $display("FAIL midfill_word%0d got %h want %h", w, sprite_addr, ref_mem[w]); end
        end
    endtask

    initial begin
        test_reset();
        test_fill(4'($urandom), 1'b0);
        test_word_write();
        test_tile_write();
        test_random_words();
        test_fill(last_fill ^ 4'($urandom_range(1, 15)), 1'b1);
        test_out_of_range();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
